// File: rtl/instr_fetch_seq_pkg.sv
// Shared opcode constants, idle instruction and FSM state type for the
// instruction fetch sequencer.
package instr_fetch_seq_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_OUT  = 2'b11;

  localparam logic [7:0] NOP_INSTR = 8'h40;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_DONE
  } state_t;

  function automatic logic is_load(input logic [7:0] w);
    return w[7:6] == OP_LOAD;
  endfunction

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Program-load, control and processor-facing bus of the fetch sequencer.
interface instr_fetch_seq_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          step_mode;
  logic          step;
  logic [7:0]    INSTR;
  logic [7:0]    Load;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   pc;

  modport master (
    output wr_en, wr_addr, wr_data, prog_len, start, step_mode, step,
    input  INSTR, Load, busy, done, err, pc
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, prog_len, start, step_mode, step,
    output INSTR, Load, busy, done, err, pc
  );

endinterface

// File: rtl/instr_fetch_seq_prog_store.sv
// DEPTH x 8 program store: gated synchronous write, two combinational reads
// (opcode word and the following immediate word).
module prog_store #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic          wr_allow,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr0,
  output logic [7:0]    rd_data0,
  input  logic [AW-1:0] rd_addr1,
  output logic [7:0]    rd_data1
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && wr_allow) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data0 = mem[rd_addr0];
  assign rd_data1 = mem[rd_addr1];

endmodule

// File: rtl/instr_fetch_seq.sv
// Program sequencer: steps a PC through the program store and drives the
// processor's INSTR/Load buses, one instruction per clock (or per step).
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter int         DEPTH = 16,
  parameter logic [7:0] NOP   = NOP_INSTR
) (
  input  logic              CLK,
  input  logic              RST,
  instr_fetch_seq_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  state_t        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [PW-1:0] len_q, len_d;
  logic          step_q, step_d;
  logic [7:0]    instr_q, instr_d;
  logic [7:0]    load_q, load_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  logic          wr_allow;
  logic [PW-1:0] pc_inc;
  logic [7:0]    word0, word1;

  assign pc_inc   = pc_q + PW'(1);
  assign wr_allow = (state_q == S_IDLE) || (state_q == S_DONE);

  prog_store #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store (
    .clk      (CLK),
    .wr_en    (bus.wr_en),
    .wr_allow (wr_allow),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .rd_addr0 (pc_q[AW-1:0]),
    .rd_data0 (word0),
    .rd_addr1 (pc_inc[AW-1:0]),
    .rd_data1 (word1)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      step_q  <= 1'b0;
      instr_q <= NOP;
      load_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      step_q  <= step_d;
      instr_q <= instr_d;
      load_q  <= load_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    step_d  = step_q;
    instr_d = NOP;
    load_d  = load_q;
    err_d   = err_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          len_d  = bus.prog_len;
          step_d = bus.step_mode;
          pc_d   = '0;
          err_d  = 1'b0;
          if (bus.prog_len == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = bus.step_mode ? S_WAIT : S_RUN;
          end
        end
      end

      S_WAIT: begin
        if (bus.step) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        instr_d = word0;
        if (is_load(word0)) begin
          // A LOAD whose immediate would lie past len is truncated: flag it
          // and end the program rather than read beyond the valid words.
          if (pc_inc < len_q) begin
            load_d = word1;
            pc_d   = pc_q + PW'(2);
          end else begin
            load_d = '0;
            err_d  = 1'b1;
            pc_d   = len_q;
          end
        end else begin
          pc_d = pc_inc;
        end
        if (pc_d >= len_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = step_q ? S_WAIT : S_RUN;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.INSTR = instr_q;
  assign bus.Load  = load_q;
  assign bus.busy  = (state_q == S_RUN) || (state_q == S_WAIT);
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.pc    = pc_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: directed program scenarios plus
// randomized programs checked against a program-walk reference model.
module tb_instr_fetch_seq;
  import instr_fetch_seq_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;

  logic clk = 1'b0;
  logic rst;

  instr_fetch_seq_if #(.DEPTH(DEPTH)) bus ();

  instr_fetch_seq #(.DEPTH(DEPTH)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] ref_mem [DEPTH];
  logic [7:0] m_load;
  logic [7:0] exp_i[$];
  logic [7:0] exp_l[$];
  logic       exp_e[$];
  int         exp_p[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
    ref_mem[a]  = d;
  endtask

  // Walk the program as the processor would see it: list of issued words,
  // the Load value after each issue, the sticky error and the PC.
  task automatic build_model(input int len);
    int pc;
    logic [7:0] w, ld;
    logic e;
    exp_i.delete(); exp_l.delete(); exp_e.delete(); exp_p.delete();
    pc = 0; e = 1'b0; ld = m_load;
    while (pc < len) begin
      w = ref_mem[pc];
      if (w[7:6] == OP_LOAD) begin
        if (pc + 1 < len) begin
          ld = ref_mem[pc + 1];
          pc = pc + 2;
        end else begin
          ld = 8'h00;
          e  = 1'b1;
          pc = len;
        end
      end else begin
        pc = pc + 1;
      end
      exp_i.push_back(w);
      exp_l.push_back(ld);
      exp_e.push_back(e);
      exp_p.push_back(pc);
    end
  endtask

  task automatic run(input int len, input logic stepm);
    int n;
    bus.prog_len  = PW'(len);
    bus.step_mode = stepm;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    build_model(len);
    n = exp_i.size();
    check("start_instr", bus.INSTR, NOP_INSTR);
    check("start_load", bus.Load, m_load);
    check("start_err", bus.err, 0);
    check("start_pc", bus.pc, 0);
    if (n == 0) begin
      check("len0_done", bus.done, 1);
      check("len0_busy", bus.busy, 0);
      tick();
      check("len0_done_end", bus.done, 0);
      check("len0_busy_end", bus.busy, 0);
      check("len0_instr", bus.INSTR, NOP_INSTR);
      return;
    end
    check("start_busy", bus.busy, 1);
    check("start_done", bus.done, 0);
    for (int k = 0; k < n; k++) begin
      if (stepm) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          check("wait_instr", bus.INSTR, NOP_INSTR);
          check("wait_busy", bus.busy, 1);
        end
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        check("step_instr", bus.INSTR, NOP_INSTR);
        check("step_busy", bus.busy, 1);
      end
      tick();
      check("issue_instr", bus.INSTR, exp_i[k]);
      check("issue_load", bus.Load, exp_l[k]);
      check("issue_err", bus.err, exp_e[k]);
      check("issue_pc", bus.pc, exp_p[k]);
      check("issue_done", bus.done, (k == n - 1) ? 1 : 0);
      check("issue_busy", bus.busy, (k == n - 1) ? 0 : 1);
    end
    m_load = exp_l[n - 1];
    tick();
    check("end_instr", bus.INSTR, NOP_INSTR);
    check("end_done", bus.done, 0);
    check("end_busy", bus.busy, 0);
    check("end_pc", bus.pc, len);
    check("end_err", bus.err, exp_e[n - 1]);
  endtask

  task automatic load_demo();
    write_word(0, 8'b00_000_000);
    write_word(1, 8'h05);
    write_word(2, 8'b01_001_000);
    write_word(3, 8'b10_010_001);
    write_word(4, 8'b11_010_000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int len;
    logic [7:0] w;

    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.prog_len = '0; bus.start = 1'b0; bus.step_mode = 1'b0; bus.step = 1'b0;
    tick(); tick();
    check("rst_instr", bus.INSTR, NOP_INSTR);
    check("rst_load", bus.Load, 8'h00);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_pc", bus.pc, 0);
    rst = 1'b0;
    m_load = 8'h00;

    load_demo();
    run(5, 1'b0);

    // Write attempted while running must be dropped.
    bus.prog_len = PW'(5); bus.step_mode = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = AW'(3); bus.wr_data = 8'hFF;
    tick();
    bus.wr_en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = bus.done;
    end
    check("blocked_run_done", seen, 1);
    m_load = 8'h05;
    run(5, 1'b0);

    run(5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      check("done_step_instr", bus.INSTR, NOP_INSTR);
      check("done_step_busy", bus.busy, 0);
      check("done_step_done", bus.done, 0);
      check("done_step_pc", bus.pc, 5);
    end

    run(0, 1'b0);

    write_word(0, 8'h48);
    write_word(1, 8'h00);
    run(2, 1'b0);
    run(2, 1'b0);

    // Reset in the second RUN cycle.
    load_demo();
    bus.prog_len = PW'(5); bus.step_mode = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_instr", bus.INSTR, NOP_INSTR);
    check("midrst_load", bus.Load, 8'h00);
    check("midrst_pc", bus.pc, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    m_load = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("postrst_done", bus.done, 0);
      check("postrst_instr", bus.INSTR, NOP_INSTR);
    end
    run(5, 1'b0);

    // Write and start in the same cycle: the write is visible to the first fetch.
    bus.wr_en = 1'b1; bus.wr_addr = AW'(0); bus.wr_data = 8'hC3;
    ref_mem[0] = 8'hC3;
    run(5, 1'b0);

    for (int t = 0; t < 20; t++) begin
      for (int a = 0; a < DEPTH; a++) begin
        w = 8'($urandom);
        if ($urandom_range(0, 2) == 0) w[7:6] = OP_LOAD;
        write_word(a, w);
      end
      if (t == 0)      len = DEPTH;
      else if (t == 1) len = 0;
      else             len = $urandom_range(0, DEPTH);
      run(len, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
